// File: rtl/work_buffer_rr_scheduler.sv
// Round-robin scheduler sharing one single-port work buffer RAM between four pipeline stages.
// Latency: one IDLE arbitration cycle per grant, then one transfer per cycle; read data returns 1 cycle after mem_ren.
// Backpressure: only the granted stage sees req_ready; a grant ends when its stage drops valid or after BURST_MAX transfers.
//
// Requesters: 0=MDCT, 1=spectral, 2=quant, 3=entropy.
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   req_valid/addr/wdata/wen  per-requester request, packed (requester i at [i*W +: W])
//   req_ready                 one-hot accept strobe, asserted in the cycle the transfer fires
//   rsp_valid/rsp_rdata       one-hot read response to the issuing requester, shared data bus
//   mem_addr/wdata/wen/ren    RAM command port, zero when no access is issued
//   mem_rdata                 RAM read data, valid the cycle after mem_ren
//   area_err                  sticky out-of-area access flag
// Build option: define WBS_AREA_CHECK_EN to restrict requester i to the 1K-word area
// addr[AW-1:AW-2]==i; otherwise every address passes through and area_err is tied 0.

module work_buffer_rr_scheduler #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_MAX  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_valid,
    input  logic [4*ADDR_WIDTH-1:0] req_addr,
    input  logic [4*DATA_WIDTH-1:0] req_wdata,
    input  logic [3:0]              req_wen,
    output logic [3:0]              req_ready,
    output logic [3:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic                    mem_wen,
    output logic                    mem_ren,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    area_err
);

    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state;
    logic [1:0]              owner;
    logic [1:0]              rr_ptr;
    logic [CW-1:0]           burst_cnt;

    // Read-return tracking: one read can be outstanding per cycle.
    logic                    rd_pend;
    logic [1:0]              rd_id;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    area_err_q;

    // Owner's request fields
    logic                    own_vld;
    logic                    own_wen;
    logic [ADDR_WIDTH-1:0]   own_addr;
    logic [DATA_WIDTH-1:0]   own_wdata;

    logic                    fire;
    logic                    in_area;
    logic                    mem_go;
    logic                    last_xfer;

    logic [1:0]              win;
    logic                    win_found;

    always_comb begin
        own_vld   = req_valid[owner];
        own_wen   = req_wen[owner];
        own_addr  = req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
        own_wdata = req_wdata[owner*DATA_WIDTH +: DATA_WIDTH];
    end

    // Outputs are forced quiet while rst is high so nothing leaks out during the
    // reset cycle, even before the state registers have been cleared.
    assign fire      = !rst && (state == BUSY) && own_vld;
    assign last_xfer = (burst_cnt == CW'(BURST_MAX - 1));

`ifdef WBS_AREA_CHECK_EN
    assign in_area = (own_addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == owner);
`else
    assign in_area = 1'b1;
`endif

    // An out-of-area fire is still accepted and counted, but never reaches the RAM.
    assign mem_go = fire && in_area;

    // Round-robin pick: first requester at or after rr_ptr, wrapping mod 4.
    always_comb begin
        win       = rr_ptr;
        win_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && req_valid[rr_ptr + 2'(k)]) begin
                win       = rr_ptr + 2'(k);
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 2'd0;
            rr_ptr     <= 2'd0;
            burst_cnt  <= '0;
            rd_pend    <= 1'b0;
            rd_id      <= 2'd0;
            rdata_q    <= '0;
            area_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner     <= win;
                        burst_cnt <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (fire) begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                    // Dropping valid gives the grant up at once; the stage must re-arbitrate.
                    if (!own_vld || (fire && last_xfer)) begin
                        rr_ptr <= owner + 2'd1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // The response id is captured with the read itself, so a grant
            // change in the same cycle cannot misroute the returning data.
            rd_pend <= mem_go && !own_wen;
            rd_id   <= owner;
            if (rd_pend) begin
                rdata_q <= mem_rdata;
            end

            if (fire && !in_area) begin
                area_err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = fire ? (4'd1 << owner) : 4'd0;
        mem_addr  = mem_go ? own_addr  : '0;
        mem_wdata = mem_go ? own_wdata : '0;
        mem_wen   = mem_go && own_wen;
        mem_ren   = mem_go && !own_wen;
    end

    // Read data is forwarded straight from the RAM in its valid cycle and the
    // last returned word is held afterwards. A reset arriving while a read is
    // returning suppresses the response.
    always_comb begin
        rsp_valid = (rd_pend && !rst) ? (4'd1 << rd_id) : 4'd0;
        if (rst) begin
            rsp_rdata = '0;
        end else if (rd_pend) begin
            rsp_rdata = mem_rdata;
        end else begin
            rsp_rdata = rdata_q;
        end
    end

`ifdef WBS_AREA_CHECK_EN
    assign area_err = area_err_q && !rst;
`else
    assign area_err = 1'b0;
`endif

endmodule

// File: tb/tb_work_buffer_rr_scheduler.sv
module tb_work_buffer_rr_scheduler;

    localparam int AW = 12;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_wdata;
    logic [3:0]      req_wen;
    logic [3:0]      req_ready;
    logic [3:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_wen;
    logic            mem_ren;
    logic [DW-1:0]   mem_rdata;
    logic            area_err;

    always #5 clk = ~clk;

    work_buffer_rr_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata), .req_wen(req_wen),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata), .area_err(area_err)
    );

    // RAM model: 1-cycle read latency
    logic [DW-1:0] mem_arr [0:4095];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_wen) mem_arr[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem_arr[mem_addr];
    end

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] d;
    } rsp_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [1:0]  exp_fire [$];
    rsp_t        exp_rsp  [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every accept and every read response is popped against the scoreboard.
    always @(negedge clk) begin
        logic [1:0] e;
        rsp_t       r;
        if (req_ready != 4'h0) begin
            if (exp_fire.size() == 0) begin
                check("fire_unexpected", {28'h0, req_ready}, 32'h0);
            end else begin
                e = exp_fire.pop_front();
                check("fire_owner", {28'h0, req_ready}, {28'h0, 4'd1 << e});
            end
        end
        if (rsp_valid != 4'h0) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", {28'h0, rsp_valid}, 32'h0);
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_id", {28'h0, rsp_valid}, {28'h0, 4'd1 << r.id});
                check("rsp_data", rsp_rdata, r.d);
            end
        end
        if (mem_wen || mem_ren) begin
            check("mem_wen_ren_excl", {31'h0, mem_wen && mem_ren}, 32'h0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fires;
        int cycles;

        // Test 1: reset with all requesters asserting
        rst       = 1'b1;
        req_valid = 4'hF;
        req_wen   = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, AW'((i << 10) | 10'h3FF), 32'h1000 + i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {28'h0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_mem_cmd", {29'h0, mem_wen, mem_ren, area_err}, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        exp_fire.push_back(2'd0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t1_bubble", {28'h0, req_ready}, 32'h0);
        next_cyc();
        @(negedge clk);
        check("t1_first_grant", {28'h0, req_ready}, 32'h1);
        next_cyc();
        req_valid = 4'h0;

        // Test 2: single read by requester 2
        do_reset();
        mem_arr[12'h805] = 32'hDEADBEEF;
        set_req(2, 12'h805, 32'h0);
        req_wen   = 4'h0;
        req_valid = 4'b0100;
        exp_fire.push_back(2'd2);
        exp_rsp.push_back('{id: 2'd2, d: 32'hDEADBEEF});
        @(negedge clk);
        check("t2_bubble_ren", {31'h0, mem_ren}, 32'h0);
        next_cyc();
        @(negedge clk);
        check("t2_mem_ren", {31'h0, mem_ren}, 32'h1);
        check("t2_mem_addr", {20'h0, mem_addr}, 32'h805);
        next_cyc();
        req_valid = 4'h0;
        @(negedge clk);
        check("t2_rsp_valid", {28'h0, rsp_valid}, 32'h4);
        next_cyc();
        @(negedge clk);
        check("t2_rsp_idle", {28'h0, rsp_valid}, 32'h0);
        check("t2_rsp_hold", rsp_rdata, 32'hDEADBEEF);

        // Test 3: fairness, all four requesting continuously
        next_cyc();
        do_reset();
        req_wen = 4'hF;
        for (int i = 0; i < 4; i++) set_req(i, AW'((i << 10) | 10'h3FF), 32'h2000 + i);
        for (int b = 0; b < 5; b++)
            for (int k = 0; k < 16; k++) exp_fire.push_back(2'(b));
        req_valid = 4'hF;
        fires  = 0;
        cycles = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            cycles++;
            if (req_ready != 4'h0) fires++;
            if (fires == 80) break;
            next_cyc();
        end
        check("t3_fire_count", fires, 80);
        check("t3_cycle_count", cycles, 85);
        next_cyc();
        req_valid = 4'h0;

        // Test 4: early release by requester 1 while requester 3 waits
        next_cyc();
        do_reset();
        set_req(1, 12'h4FF, 32'h3001);
        set_req(3, 12'hCFF, 32'h3003);
        req_wen   = 4'b1010;
        req_valid = 4'b1010;
        repeat (3) exp_fire.push_back(2'd1);
        exp_fire.push_back(2'd3);
        @(negedge clk);
        check("t4_bubble", {28'h0, req_ready}, 32'h0);
        repeat (4) next_cyc();
        req_valid = 4'b1000;
        @(negedge clk);
        check("t4_release", {28'h0, req_ready}, 32'h0);
        next_cyc();
        @(negedge clk);
        check("t4_idle_bubble", {28'h0, req_ready}, 32'h0);
        check("t4_rr_ptr", {30'h0, dut.rr_ptr}, 32'h2);
        next_cyc();
        @(negedge clk);
        check("t4_grant3", {28'h0, req_ready}, 32'h8);
        next_cyc();
        req_valid = 4'h0;

        // Test 5: reset in the cycle after a read is issued
        next_cyc();
        do_reset();
        mem_arr[12'h005] = 32'h12345678;
        set_req(0, 12'h005, 32'h0);
        req_wen   = 4'h0;
        req_valid = 4'b0001;
        exp_fire.push_back(2'd0);
        @(negedge clk);
        next_cyc();
        @(negedge clk);
        check("t5_mem_ren", {31'h0, mem_ren}, 32'h1);
        next_cyc();
        rst       = 1'b1;
        req_valid = 4'h0;
        @(negedge clk);
        check("t5_rsp_killed", {28'h0, rsp_valid}, 32'h0);
        next_cyc();
        next_cyc();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t5_no_late_rsp", {28'h0, rsp_valid}, 32'h0);
        end

        // Test 6: back-to-back reads by requester 3
        next_cyc();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mem_arr[12'hC00 + k] = 32'hA0000000 + k;
            exp_fire.push_back(2'd3);
            exp_rsp.push_back('{id: 2'd3, d: 32'hA0000000 + k});
        end
        set_req(3, 12'hC00, 32'h0);
        req_wen   = 4'h0;
        req_valid = 4'b1000;
        next_cyc();
        next_cyc();
        set_req(3, 12'hC01, 32'h0);
        @(negedge clk);
        check("t6_rsp0", {28'h0, rsp_valid}, 32'h8);
        next_cyc();
        set_req(3, 12'hC02, 32'h0);
        @(negedge clk);
        check("t6_rsp1", {28'h0, rsp_valid}, 32'h8);
        next_cyc();
        req_valid = 4'h0;
        @(negedge clk);
        check("t6_rsp2", {28'h0, rsp_valid}, 32'h8);
        next_cyc();

`ifdef WBS_AREA_CHECK_EN
        // Test 7: out-of-area write by requester 0
        do_reset();
        set_req(0, 12'h400, 32'h55);
        req_wen   = 4'h1;
        req_valid = 4'b0001;
        exp_fire.push_back(2'd0);
        @(negedge clk);
        next_cyc();
        @(negedge clk);
        check("t7_ready", {28'h0, req_ready}, 32'h1);
        check("t7_mem_wen", {31'h0, mem_wen}, 32'h0);
        next_cyc();
        req_valid = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t7_area_err_sticky", {31'h0, area_err}, 32'h1);
            next_cyc();
        end
        do_reset();
        @(negedge clk);
        check("t7_area_err_cleared", {31'h0, area_err}, 32'h0);
        next_cyc();
`else
        @(negedge clk);
        check("area_err_tied", {31'h0, area_err}, 32'h0);
        next_cyc();
`endif

        repeat (3) next_cyc();
        check("drain_fire_q", exp_fire.size(), 32'h0);
        check("drain_rsp_q", exp_rsp.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
